// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared types, register map and byte-merge helper for the countdown timer
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [31:0] OFF_CTRL   = 32'h0;
    localparam logic [31:0] OFF_PRESET = 32'h4;
    localparam logic [31:0] OFF_COUNT  = 32'h8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - data-bus responder interface for the countdown timer
interface countdown_timer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic        sel;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output byteen, output sel, input  rdata);
    modport slave  (input  addr, input  wdata, input  byteen, input  sel, output rdata);
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - memory-mapped countdown timer with one-shot and auto-reload modes
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus,
    output logic              irq
);

    state_t      state_q, state_d;
    logic        en_q, im_q, pend_q;
    logic [1:0]  mode_q;
    logic [31:0] preset_q, count_q, count_d;
    logic        pend_set, pend_clr, en_clr;

    logic [29:0] word_off;
    logic        hit_ctrl, hit_preset, hit_count;
    logic        wr, wr_ctrl, wr_preset;
    logic [3:0]  ctrl_bits, ctrl_new;
    logic        addr_lo_unused;

    // Word offset relative to the base; the byte lane bits never take part in decode.
    assign word_off       = bus.addr[31:2] - BASE_ADDR[31:2];
    assign addr_lo_unused = &bus.addr[1:0];
    assign hit_ctrl       = (word_off == OFF_CTRL[31:2]);
    assign hit_preset     = (word_off == OFF_PRESET[31:2]);
    assign hit_count      = (word_off == OFF_COUNT[31:2]);

    assign wr        = bus.sel & (|bus.byteen);
    assign wr_ctrl   = wr & hit_ctrl;
    assign wr_preset = wr & hit_preset;

    assign ctrl_bits = {im_q, mode_q, en_q};
    assign ctrl_new  = bus.byteen[0] ? bus.wdata[3:0] : ctrl_bits;

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.sel) begin
            if (hit_ctrl)        bus.rdata = {28'h0, ctrl_bits};
            else if (hit_preset) bus.rdata = preset_q;
            else if (hit_count)  bus.rdata = count_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        en_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = 32'h0;
                    state_d  = ST_INT;
                    pend_set = 1'b1;
                    // Modes other than auto-reload behave as one-shot and disarm themselves.
                    en_clr   = (mode_q != MODE_RELOAD);
                end
            end
            ST_INT: begin
                if (mode_q == MODE_RELOAD) begin
                    state_d  = ST_LOAD;
                    pend_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= 32'h0;
            pend_q   <= 1'b0;
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            im_q     <= 1'b0;
            preset_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;

            // A CTRL write acknowledges the interrupt and overrides any internal update.
            if (wr_ctrl)       pend_q <= 1'b0;
            else if (pend_set) pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;

            if (wr_ctrl) begin
                en_q   <= ctrl_new[CTRL_EN];
                mode_q <= ctrl_new[CTRL_MODE_HI:CTRL_MODE_LO];
                im_q   <= ctrl_new[CTRL_IM];
            end else if (en_clr) begin
                en_q <= 1'b0;
            end

            if (wr_preset) preset_q <= byte_merge(preset_q, bus.wdata, bus.byteen);
        end
    end

    assign irq = im_q & pend_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a timer that is armed, has loaded its preset, or has fired.
    logic        m_en, m_im, m_pend;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    bit          m_active, m_loaded, m_fired;

    logic [31:0] got_rd, exp_rd;
    logic        got_irq, exp_irq;

    typedef struct {
        logic [31:0] off;
        logic [31:0] data;
        logic [3:0]  be;
        logic        sel;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_im = 0; m_pend = 0; m_mode = 0;
        m_preset = 0; m_count = 0;
        m_active = 0; m_loaded = 0; m_fired = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic s);
        logic [31:0] w;
        w = a & ~32'h3;
        if (!s) return 32'h0;
        if (w == BASE)         return {28'h0, m_im, m_mode, m_en};
        if (w == BASE + 32'h4) return m_preset;
        if (w == BASE + 32'h8) return m_count;
        return 32'h0;
    endfunction

    task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic s);
        bit clr_en;
        logic [31:0] w;
        clr_en = 0;
        if (m_fired) begin
            m_fired  = 0;
            m_loaded = 0;
            if (m_mode == 2'd1) m_pend = 0;
            else                m_active = 0;
        end else if (!m_active) begin
            if (m_en) m_active = 1;
        end else if (!m_loaded) begin
            m_count  = m_preset;
            m_loaded = 1;
        end else if (!m_en) begin
            m_active = 0;
            m_loaded = 0;
        end else if (m_count > 1) begin
            m_count = m_count - 1;
        end else begin
            m_count = 0;
            m_fired = 1;
            m_pend  = 1;
            if (m_mode != 2'd1) clr_en = 1;
        end
        if (clr_en) m_en = 0;
        w = a & ~32'h3;
        if (s && be != 4'h0) begin
            if (w == BASE) begin
                if (be[0]) {m_im, m_mode, m_en} = d[3:0];
                m_pend = 0;
            end else if (w == BASE + 32'h4) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_preset[8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    // One bus cycle: read sampled mid-cycle before the edge, irq sampled just after it.
    task automatic op(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic s);
        @(negedge clk);
        bus.addr = a; bus.wdata = d; bus.byteen = be; bus.sel = s;
        #1;
        got_rd = bus.rdata;
        exp_rd = model_read(a, s);
        @(posedge clk);
        model_step(a, d, be, s);
        #1;
        got_irq = irq;
        exp_irq = m_im & m_pend;
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
        op(BASE + off, d, 4'hF, 1'b1);
    endtask

    task automatic rd_reg(input logic [31:0] off);
        op(BASE + off, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] oneshot_cnt(input int k);
        if (k == 2) return 32'd3;
        if (k == 3) return 32'd2;
        if (k == 4) return 32'd1;
        return 32'd0;
    endfunction

    function automatic logic [31:0] reload_cnt(input int k);
        if (k < 2) return 32'd0;
        case ((k - 2) % 4)
            0:       return 32'd2;
            1:       return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        bus.addr = 0; bus.wdata = 0; bus.byteen = 0; bus.sel = 0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("reset_irq", {31'h0, irq}, 32'h0);

        tbl.push_back('{32'h0, 32'h0,        4'h0, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h4, 32'h0,        4'h0, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h8, 32'h0,        4'h0, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'hC, 32'h0,        4'h0, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h4, 32'hAABBCCDD, 4'h2, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h4, 32'h0,        4'h0, 1'b1, 32'h0000CC00, 1'b0});
        tbl.push_back('{32'h8, 32'h00001234, 4'hF, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h8, 32'h0,        4'h0, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h4, 32'h00000055, 4'hF, 1'b0, 32'h0,      1'b0});
        tbl.push_back('{32'h4, 32'h0,        4'h0, 1'b1, 32'h0000CC00, 1'b0});
        tbl.push_back('{32'h0, 32'hFFFFFFF0, 4'hF, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h0, 32'h0,        4'h0, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h0, 32'h00000006, 4'h1, 1'b1, 32'h0,      1'b0});
        tbl.push_back('{32'h0, 32'h0,        4'h0, 1'b1, 32'h6,      1'b0});
        tbl.push_back('{32'h0, 32'h0,        4'hF, 1'b1, 32'h6,      1'b0});
        tbl.push_back('{32'h0, 32'h0,        4'h0, 1'b1, 32'h0,      1'b0});
        foreach (tbl[i]) begin
            op(BASE + tbl[i].off, tbl[i].data, tbl[i].be, tbl[i].sel);
            chk($sformatf("tbl%0d_rdata", i), got_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), {31'h0, got_irq}, {31'h0, tbl[i].exp_irq});
        end

        // One-shot, PRESET=3: irq rises after E5 and holds until CTRL is written.
        wr_reg(32'h4, 32'd3);
        wr_reg(32'h0, 32'h9);
        for (int j = 1; j <= 8; j++) begin
            rd_reg(32'h8);
            chk($sformatf("os_count_e%0d", j - 1), got_rd, oneshot_cnt(j - 1));
            chk($sformatf("os_irq_e%0d", j), {31'h0, got_irq}, {31'h0, (j >= 5)});
        end
        rd_reg(32'h0);
        chk("os_ctrl_autoclr", got_rd, 32'h8);
        chk("os_irq_held", {31'h0, got_irq}, 32'h1);
        wr_reg(32'h0, 32'h8);
        chk("os_ack_irq", {31'h0, got_irq}, 32'h0);
        for (int j = 0; j < 3; j++) begin
            rd_reg(32'h8);
            chk("os_after_count", got_rd, 32'h0);
            chk("os_after_irq", {31'h0, got_irq}, 32'h0);
        end

        // Auto-reload, PRESET=2: one-cycle irq every 4 cycles.
        wr_reg(32'h4, 32'd2);
        wr_reg(32'h0, 32'hB);
        for (int j = 1; j <= 13; j++) begin
            rd_reg(32'h8);
            chk($sformatf("ar_count_e%0d", j - 1), got_rd, reload_cnt(j - 1));
            chk($sformatf("ar_irq_e%0d", j), {31'h0, got_irq}, {31'h0, (j % 4 == 0)});
        end
        wr_reg(32'h0, 32'h0);
        repeat (3) rd_reg(32'h0);
        chk("ar_stop_irq", {31'h0, got_irq}, 32'h0);

        // PRESET=1 fires after E3; then asynchronous reset drops irq between edges.
        wr_reg(32'h4, 32'd1);
        wr_reg(32'h0, 32'h9);
        for (int j = 1; j <= 4; j++) begin
            rd_reg(32'h0);
            chk($sformatf("p1_irq_e%0d", j), {31'h0, got_irq}, {31'h0, (j >= 3)});
        end
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 chk("async_irq_drop", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-count with COUNT=5.
        wr_reg(32'h4, 32'd5);
        wr_reg(32'h0, 32'h9);
        rd_reg(32'h8);
        rd_reg(32'h8);
        rd_reg(32'h8);
        chk("mid_count_before", got_rd, 32'd5);
        @(negedge clk);
        bus.addr = BASE + 32'h8; bus.byteen = 4'h0; bus.sel = 1'b1;
        #2 reset = 1'b0;
        model_reset();
        #1 chk("async_count_clear", bus.rdata, 32'h0);
        chk("async_irq_low", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            rd_reg(32'h8);
            chk("post_reset_count", got_rd, 32'h0);
            chk("post_reset_irq", {31'h0, got_irq}, 32'h0);
        end

        // Randomized traffic against the reference model.
        sync_reset();
        for (int n = 0; n < 800; n++) begin
            int r;
            logic [31:0] a, d;
            logic [3:0]  be;
            logic        s;
            r  = $urandom_range(0, 99);
            a  = BASE + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            d  = $urandom;
            be = 4'h0;
            s  = 1'b1;
            if (r < 6) begin
                a  = BASE + 32'($urandom_range(0, 3));
                be = 4'($urandom_range(1, 15));
            end else if (r < 12) begin
                a  = BASE + 32'h4;
                d  = 32'($urandom_range(0, 6));
                be = 4'hF;
            end else if (r < 14) begin
                a  = BASE + 32'h8;
                be = 4'($urandom_range(1, 15));
            end else if (r < 17) begin
                be = 4'($urandom_range(1, 15));
                s  = 1'b0;
            end else begin
                s = ($urandom_range(0, 9) != 0);
            end
            op(a, d, be, s);
            chk("rnd_rdata", got_rd, exp_rd);
            chk("rnd_irq", {31'h0, got_irq}, {31'h0, exp_irq});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
